// File: rtl/mib_access_arbiter.sv
// Round-robin arbiter giving several MIB requesters one-at-a-time access to mibController,
// with one-deep per-channel request latches, busy-fall completion and an access timeout.
module mib_access_arbiter #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                  macCoreClk,
    input  logic                  macCoreClkHardRst_n,
    input  logic [NCH-1:0]        reqWr,
    input  logic [NCH-1:0]        reqRd,
    input  logic [NCH*ADDR_W-1:0] reqAddr,
    input  logic [NCH*DATA_W-1:0] reqWrData,
    output logic [NCH-1:0]        reqReady,
    output logic [NCH-1:0]        reqDataValid,
    output logic [NCH-1:0]        reqError,
    output logic [DATA_W-1:0]     reqRdData,
    output logic [ADDR_W-1:0]     mibAddr,
    output logic [DATA_W-1:0]     mibWrData,
    output logic                  mibWr,
    output logic                  mibRd,
    input  logic                  mibBusy,
    input  logic [DATA_W-1:0]     mibRdData
);

    localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StComplete,
        StDrain
    } state_e;

    state_e            state;
    logic [NCH-1:0]    pending;
    logic [NCH-1:0]    latWr;
    logic [NCH-1:0]    newReq;
    logic [ADDR_W-1:0] latAddr [NCH];
    logic [DATA_W-1:0] latData [NCH];
    logic [IDX_W-1:0]  rrPtr;
    logic [IDX_W-1:0]  gntIdx;
    logic [IDX_W-1:0]  selIdx;
    logic              selValid;
    logic              busyQ;
    logic              busyFall;
    logic              counting;
    logic              timeoutHit;
    logic [CNT_W-1:0]  toCnt;
    int unsigned       cand;

    assign newReq     = (reqWr | reqRd) & ~pending;
    assign reqReady   = ~(reqWr | reqRd | pending);
    assign counting   = (state == StIssue) || (state == StWaitBusy) || (state == StWaitDone);
    assign busyFall   = (state == StWaitDone) && !mibBusy && busyQ;
    assign timeoutHit = (TIMEOUT != 0) && counting && ((toCnt + CNT_W'(1)) == CNT_W'(TIMEOUT));

    // Scan downwards so the candidate nearest to rrPtr+1 is the one left selected.
    always_comb begin
        selValid = 1'b0;
        selIdx   = '0;
        cand     = 0;
        for (int unsigned k = NCH; k >= 1; k--) begin
            cand = (32'(rrPtr) + k) % NCH;
            if (pending[IDX_W'(cand)]) begin
                selValid = 1'b1;
                selIdx   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge macCoreClk or negedge macCoreClkHardRst_n) begin
        if (!macCoreClkHardRst_n) begin
            state        <= StIdle;
            pending      <= '0;
            latWr        <= '0;
            for (int i = 0; i < NCH; i++) begin
                latAddr[i] <= '0;
                latData[i] <= '0;
            end
            rrPtr        <= IDX_W'(NCH - 1);
            gntIdx       <= '0;
            busyQ        <= 1'b0;
            toCnt        <= '0;
            reqDataValid <= '0;
            reqError     <= '0;
            reqRdData    <= '0;
            mibAddr      <= '0;
            mibWrData    <= '0;
            mibWr        <= 1'b0;
            mibRd        <= 1'b0;
        end else begin
            busyQ        <= mibBusy;
            mibWr        <= 1'b0;
            mibRd        <= 1'b0;
            reqDataValid <= '0;
            reqError     <= '0;
            if (counting) begin
                toCnt <= toCnt + CNT_W'(1);
            end

            // A write wins over a simultaneous read on the same channel.
            for (int i = 0; i < NCH; i++) begin
                if (newReq[i]) begin
                    pending[i] <= 1'b1;
                    latWr[i]   <= reqWr[i];
                    latAddr[i] <= reqAddr[i*ADDR_W +: ADDR_W];
                    latData[i] <= reqWrData[i*DATA_W +: DATA_W];
                end
            end

            if (busyFall) begin
                reqDataValid[gntIdx] <= 1'b1;
                pending[gntIdx]      <= 1'b0;
                if (!latWr[gntIdx]) begin
                    reqRdData <= mibRdData;
                end
                state <= StComplete;
            end else if (timeoutHit) begin
                reqDataValid[gntIdx] <= 1'b1;
                reqError[gntIdx]     <= 1'b1;
                pending[gntIdx]      <= 1'b0;
                state                <= StDrain;
            end else begin
                case (state)
                    StIdle: begin
                        if (!mibBusy && selValid) begin
                            gntIdx    <= selIdx;
                            rrPtr     <= selIdx;
                            mibAddr   <= latAddr[selIdx];
                            mibWrData <= latData[selIdx];
                            mibWr     <= latWr[selIdx];
                            mibRd     <= ~latWr[selIdx];
                            toCnt     <= '0;
                            state     <= StIssue;
                        end
                    end
                    StIssue:    state <= StWaitBusy;
                    StWaitBusy: if (mibBusy) state <= StWaitDone;
                    StWaitDone: state <= StWaitDone;
                    StComplete: state <= StIdle;
                    StDrain:    if (!mibBusy) state <= StIdle;
                    default:    state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mib_access_arbiter.sv
// Directed scoreboard bench for mib_access_arbiter: expected strobes and completions are queued
// as requests are posted and compared when the arbiter produces them.
module tb_mib_access_arbiter;

    localparam int NCH = 2;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int TO  = 16;

    logic              clk = 1'b0;
    logic              rstN;
    logic [NCH-1:0]    reqWr, reqRd, reqReady, reqDataValid, reqError;
    logic [NCH*AW-1:0] reqAddr;
    logic [NCH*DW-1:0] reqWrData;
    logic [DW-1:0]     reqRdData, mibWrData, mibRdData;
    logic [AW-1:0]     mibAddr;
    logic              mibWr, mibRd, mibBusy;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } issue_t;

    typedef struct {
        logic [NCH-1:0] vld;
        logic [NCH-1:0] err;
        logic [DW-1:0]  rd;
    } done_t;

    issue_t        issueQ[$];
    done_t         doneQ[$];
    logic [DW-1:0] lastRd;
    int            tests = 0;
    int            fails = 0;

    mib_access_arbiter #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .macCoreClk          (clk),
        .macCoreClkHardRst_n (rstN),
        .reqWr               (reqWr),
        .reqRd               (reqRd),
        .reqAddr             (reqAddr),
        .reqWrData           (reqWrData),
        .reqReady            (reqReady),
        .reqDataValid        (reqDataValid),
        .reqError            (reqError),
        .reqRdData           (reqRdData),
        .mibAddr             (mibAddr),
        .mibWrData           (mibWrData),
        .mibWr               (mibWr),
        .mibRd               (mibRd),
        .mibBusy             (mibBusy),
        .mibRdData           (mibRdData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int ch, input bit wr, input bit rd, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        reqWr[ch]               = wr;
        reqRd[ch]               = rd;
        reqAddr[ch*AW +: AW]    = a;
        reqWrData[ch*DW +: DW]  = d;
    endtask

    task automatic clearReq();
        reqWr = '0;
        reqRd = '0;
    endtask

    task automatic expIssue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        issue_t it;
        it.wr = wr; it.rd = ~wr; it.addr = a; it.data = d;
        issueQ.push_back(it);
    endtask

    task automatic expDone(input logic [NCH-1:0] vld, input logic [NCH-1:0] err, input bit isRd,
                           input logic [DW-1:0] rdv);
        done_t d;
        if (isRd) lastRd = rdv;
        d.vld = vld; d.err = err; d.rd = lastRd;
        doneQ.push_back(d);
    endtask

    task automatic checkIssue();
        issue_t it;
        if (issueQ.size() == 0) begin
            check("unexpected_strobe", 64'(mibWr | mibRd), 64'(0));
        end else begin
            it = issueQ.pop_front();
            check("strobe_wr", 64'(mibWr), 64'(it.wr));
            check("strobe_rd", 64'(mibRd), 64'(it.rd));
            check("strobe_addr", 64'(mibAddr), 64'(it.addr));
            if (it.wr) check("strobe_data", 64'(mibWrData), 64'(it.data));
        end
    endtask

    task automatic waitStrobe();
        int n = 0;
        while (!(mibWr | mibRd) && n < 60) begin
            tick();
            n++;
        end
        check("strobe_seen", 64'(mibWr | mibRd), 64'(1));
        if (mibWr | mibRd) checkIssue();
    endtask

    // Busy high for len cycles starting the cycle after the strobe; read data presented at the fall.
    task automatic serve(input int len, input logic [DW-1:0] rdv);
        waitStrobe();
        tick();
        mibBusy = 1'b1;
        repeat (len) tick();
        mibBusy   = 1'b0;
        mibRdData = rdv;
        tick();
    endtask

    task automatic drain();
        int n = 0;
        while (doneQ.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("done_drain", 64'(doneQ.size()), 64'(0));
    endtask

    task automatic checkReset();
        check("rst_ready", 64'(reqReady), 64'(2'b11));
        check("rst_valid", 64'(reqDataValid), 64'(0));
        check("rst_error", 64'(reqError), 64'(0));
        check("rst_rddata", 64'(reqRdData), 64'(0));
        check("rst_addr", 64'(mibAddr), 64'(0));
        check("rst_wrdata", 64'(mibWrData), 64'(0));
        check("rst_strobes", 64'({mibWr, mibRd}), 64'(0));
    endtask

    task automatic doReset();
        rstN = 1'b0;
        lastRd = '0;
        repeat (2) tick();
        checkReset();
        rstN = 1'b1;
        tick();
    endtask

    task automatic monitor();
        done_t d;
        forever begin
            @(negedge clk);
            if (rstN && reqDataValid != '0) begin
                if (doneQ.size() == 0) begin
                    check("unexpected_done", 64'(reqDataValid), 64'(0));
                end else begin
                    d = doneQ.pop_front();
                    check("done_vld", 64'(reqDataValid), 64'(d.vld));
                    check("done_err", 64'(reqError), 64'(d.err));
                    check("done_rddata", 64'(reqRdData), 64'(d.rd));
                end
            end else if (rstN && reqError != '0) begin
                check("stray_error", 64'(reqError), 64'(0));
            end
        end
    endtask

    initial begin
        rstN = 1'b0; reqWr = '0; reqRd = '0; reqAddr = '0; reqWrData = '0;
        mibBusy = 1'b0; mibRdData = '0; lastRd = '0;
        fork
            monitor();
        join_none
        doReset();

        // Write with exact cycle timing: request cycle 0, strobe 2, busy 4..7, done 9.
        post(0, 1, 0, 10'h12, 32'hDEADBEEF);
        expIssue(1, 10'h12, 32'hDEADBEEF);
        expDone(2'b01, 2'b00, 0, '0);
        #1 check("ready_low_req", 64'(reqReady), 64'(2'b10));
        tick(); clearReq();
        #1 check("ready_low_pending", 64'(reqReady), 64'(2'b10));
        tick();
        check("strobe_c2", 64'(mibWr), 64'(1));
        checkIssue();
        tick();
        check("strobe_one_cycle", 64'({mibWr, mibRd}), 64'(0));
        tick(); mibBusy = 1'b1;
        repeat (4) tick();
        mibBusy = 1'b0;
        check("no_done_c8", 64'(reqDataValid), 64'(0));
        tick();
        check("done_c9", 64'(reqDataValid), 64'(2'b01));
        check("ready_back_c9", 64'(reqReady), 64'(2'b11));
        tick();
        check("done_one_cycle", 64'(reqDataValid), 64'(0));

        // Read returns data; a following write leaves it alone.
        post(0, 0, 1, 10'h34, '0);
        expIssue(0, 10'h34, '0);
        expDone(2'b01, 2'b00, 1, 32'hCAFE0001);
        tick(); clearReq();
        serve(3, 32'hCAFE0001);
        drain();
        check("rd_data", 64'(reqRdData), 64'(32'hCAFE0001));
        post(0, 1, 0, 10'h35, 32'h11223344);
        expIssue(1, 10'h35, 32'h11223344);
        expDone(2'b01, 2'b00, 0, '0);
        tick(); clearReq();
        serve(2, 32'h5555AAAA);
        drain();
        check("rd_kept_after_wr", 64'(reqRdData), 64'(32'hCAFE0001));

        // Round-robin: both channels each round, ch0 must always go first.
        doReset();
        for (int r = 0; r < 8; r++) begin
            post(0, 1, 0, AW'(r), DW'(32'h1000 + r));
            post(1, 0, 1, AW'(32'h200 + r), '0);
            expIssue(1, AW'(r), DW'(32'h1000 + r));
            expIssue(0, AW'(32'h200 + r), '0);
            expDone(2'b01, 2'b00, 0, '0);
            expDone(2'b10, 2'b00, 1, DW'(32'hB0000000 + r));
            tick(); clearReq();
            serve(2, 32'hFFFFFFFF);
            serve(2, DW'(32'hB0000000 + r));
            drain();
        end

        // Timeout: busy never rises; done+error exactly 16 cycles after the strobe.
        post(1, 1, 0, 10'h3FF, 32'hA5A5A5A5);
        expIssue(1, 10'h3FF, 32'hA5A5A5A5);
        expDone(2'b10, 2'b10, 0, '0);
        tick(); clearReq();
        waitStrobe();
        for (int k = 1; k < TO; k++) begin
            tick();
            check("no_early_timeout", 64'(reqDataValid), 64'(0));
        end
        tick();
        check("timeout_valid", 64'(reqDataValid), 64'(2'b10));
        check("timeout_error", 64'(reqError), 64'(2'b10));
        tick();
        check("timeout_one_cycle", 64'({reqDataValid, reqError}), 64'(0));
        post(1, 0, 1, 10'h2, '0);
        expIssue(0, 10'h2, '0);
        expDone(2'b10, 2'b00, 1, 32'h0BADF00D);
        tick(); clearReq();
        serve(3, 32'h0BADF00D);
        drain();

        // Duplicate on a pending channel is dropped; wr+rd together issues only the write.
        post(1, 1, 0, 10'h100, 32'h1);
        expIssue(1, 10'h100, 32'h1);
        expDone(2'b10, 2'b00, 0, '0);
        tick();
        post(1, 0, 1, 10'h200, '0);
        post(0, 1, 1, 10'h101, 32'h2);
        expIssue(1, 10'h101, 32'h2);
        expDone(2'b01, 2'b00, 0, '0);
        #1 check("ready_dup", 64'(reqReady), 64'(2'b00));
        tick(); clearReq();
        serve(2, 32'h77777777);
        serve(2, 32'h88888888);
        drain();
        for (int k = 0; k < 6; k++) begin
            tick();
            check("no_extra_strobe", 64'({mibWr, mibRd}), 64'(0));
        end

        // Reset in WAIT_DONE aborts silently.
        post(0, 1, 0, 10'h77, 32'hFFFF0000);
        expIssue(1, 10'h77, 32'hFFFF0000);
        tick(); clearReq();
        waitStrobe();
        tick(); mibBusy = 1'b1;
        repeat (3) tick();
        rstN = 1'b0;
        lastRd = '0;
        #1 checkReset();
        tick(); mibBusy = 1'b0;
        tick();
        checkReset();
        rstN = 1'b1;
        tick();
        check("post_rst_quiet", 64'({reqDataValid, mibWr, mibRd}), 64'(0));
        post(1, 0, 1, 10'h3, '0);
        expIssue(0, 10'h3, '0);
        expDone(2'b10, 2'b00, 1, 32'h12345678);
        tick(); clearReq();
        serve(2, 32'h12345678);
        drain();
        check("post_rst_rddata", 64'(reqRdData), 64'(32'h12345678));

        repeat (3) tick();
        check("issue_q_empty", 64'(issueQ.size()), 64'(0));
        check("done_q_empty", 64'(doneQ.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
